sdram_arbiter: RTL and testbench

//  Slot-based scheduler in front of the sdram module. It shares the single sdram access port among three requesters:

---
 rtl/sdram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Slot-based scheduler sharing one sdram port among the ROM download, video and Z80 requesters.
// Each slot owner is picked in the phase-0 cycle; its access is held for the whole slot.
module sdram_arbiter #(
  parameter int unsigned SLOT_LEN   = 8,
  parameter int unsigned DATA_PHASE = 5,
  parameter int unsigned MAX_STARVE = 2,
  parameter int unsigned AW         = 23
) (
  input  logic          clk,
  input  logic          reset,
  output logic          sd_clkref,
  output logic [AW-1:0] sd_addr,
  output logic [7:0]    sd_din,
  output logic          sd_we,
  output logic          sd_oe,
  input  logic [7:0]    sd_dout,
  input  logic          dio_req,
  input  logic [AW-1:0] dio_addr,
  input  logic [7:0]    dio_din,
  output logic          dio_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic          vid_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic [1:0]    grant
);

  localparam int unsigned PW = $clog2(SLOT_LEN);
  localparam int unsigned SW = $clog2(MAX_STARVE + 2);

  localparam logic [PW-1:0] PH_DATA    = PW'(DATA_PHASE);
  localparam logic [PW-1:0] PH_ACK_SET = PW'(SLOT_LEN - 3);
  localparam logic [PW-1:0] PH_HALF    = PW'(SLOT_LEN / 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_DIO  = 2'd1,
    G_VID  = 2'd2,
    G_CPU  = 2'd3
  } grant_e;

  logic [PW-1:0] r_phase;
  logic [SW-1:0] r_starve;
  grant_e        r_grant;
  logic          r_clkref;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic          r_we;
  logic          r_oe;
  logic [7:0]    r_vid_dout;
  logic [7:0]    r_cpu_dout;
  logic          r_dio_ack;
  logic          r_vid_ack;
  logic          r_cpu_ack;

  logic [PW-1:0] w_phase_nxt;
  grant_e        w_win;

  assign w_phase_nxt = r_phase + PW'(1);

  // A starved cpu outranks video, but never the download.
  always_comb begin
    w_win = G_IDLE;
    if (dio_req)
      w_win = G_DIO;
    else if (cpu_req && (r_starve >= STARVE_MAX))
      w_win = G_CPU;
    else if (vid_req)
      w_win = G_VID;
    else if (cpu_req)
      w_win = G_CPU;
  end

  // Slot outputs become visible the clk after the phase-0 sampling cycle and
  // stay put through the following phase 0, so every slot drives for SLOT_LEN clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= '0;
      r_starve   <= '0;
      r_grant    <= G_IDLE;
      r_clkref   <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_vid_dout <= '0;
      r_cpu_dout <= '0;
      r_dio_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_clkref  <= (w_phase_nxt < PH_HALF);
      r_dio_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;

      if (r_phase == '0) begin
        r_grant <= w_win;
        unique case (w_win)
          G_DIO: begin
            r_addr <= dio_addr;
            r_din  <= dio_din;
            r_we   <= 1'b1;
            r_oe   <= 1'b0;
          end
          G_VID: begin
            r_addr <= vid_addr;
            r_we   <= 1'b0;
            r_oe   <= 1'b1;
          end
          G_CPU: begin
            r_addr <= cpu_addr;
            r_din  <= cpu_din;
            r_we   <= cpu_we;
            r_oe   <= ~cpu_we;
          end
          default: begin
            r_we <= 1'b0;
            r_oe <= 1'b0;
          end
        endcase

        if (!cpu_req || (w_win == G_CPU))
          r_starve <= '0;
        else if ((w_win == G_VID) && (r_starve < STARVE_MAX))
          r_starve <= r_starve + SW'(1);
      end

      if (r_phase == PH_DATA) begin
        if (r_grant == G_VID)
          r_vid_dout <= sd_dout;
        if ((r_grant == G_CPU) && r_oe)
          r_cpu_dout <= sd_dout;
      end

      if (r_phase == PH_ACK_SET) begin
        r_dio_ack <= (r_grant == G_DIO);
        r_vid_ack <= (r_grant == G_VID);
        r_cpu_ack <= (r_grant == G_CPU);
      end
    end
  end

  assign sd_clkref = r_clkref;
  assign sd_addr   = r_addr;
  assign sd_din    = r_din;
  assign sd_we     = r_we;
  assign sd_oe     = r_oe;
  assign dio_ack   = r_dio_ack;
  assign vid_ack   = r_vid_ack;
  assign vid_dout  = r_vid_dout;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_dout  = r_cpu_dout;
  assign grant     = r_grant;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: one table row per slot plus hand sequences for
// the late-request latency and mid-slot reset cases, against a small byte-memory model.
module tb_sdram_arbiter;

  localparam logic [22:0] DIO_A = 23'h00100;
  localparam logic [22:0] VID_A = 23'h02040;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_clkref;
  logic [22:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_we;
  logic        sd_oe;
  logic [7:0]  sd_dout;
  logic        dio_req;
  logic [22:0] dio_addr;
  logic [7:0]  dio_din;
  logic        dio_ack;
  logic        vid_req;
  logic [22:0] vid_addr;
  logic [7:0]  vid_dout;
  logic        vid_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [1:0]  grant;

  sdram_arbiter #(
    .SLOT_LEN(8),
    .DATA_PHASE(5),
    .MAX_STARVE(2),
    .AW(23)
  ) dut (
    .clk(clk), .reset(reset),
    .sd_clkref(sd_clkref), .sd_addr(sd_addr), .sd_din(sd_din),
    .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout),
    .dio_req(dio_req), .dio_addr(dio_addr), .dio_din(dio_din), .dio_ack(dio_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // Slot phase as seen by the bench: restarts at 0 while reset is sampled high.
  logic [2:0] ph;
  always @(posedge clk) ph <= reset ? 3'd0 : ph + 3'd1;

  // Byte memory model: location i starts as i[7:0]^8'h5A.
  logic [7:0] mem [4096];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (sd_we) begin
      mem[sd_addr[11:0]] <= sd_din;
    end
  end
  assign sd_dout = sd_oe ? mem[sd_addr[11:0]] : 8'h00;

  typedef struct {
    logic        dio, vid, cpu, cwe;
    logic [22:0] caddr;
    logic [7:0]  cdin, ddin;
    logic [1:0]  g;
    logic        we, oe;
    logic [22:0] a;
    logic [7:0]  din;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [13];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic d, v, c, cwe, input logic [22:0] caddr,
                              input logic [7:0] cdin, ddin, input logic [1:0] g,
                              input logic we, oe, input logic [22:0] a,
                              input logic [7:0] din, rd);
    vec_t r;
    r.dio = d; r.vid = v; r.cpu = c; r.cwe = cwe; r.caddr = caddr; r.cdin = cdin;
    r.ddin = ddin; r.g = g; r.we = we; r.oe = oe; r.a = a; r.din = din; r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the phase-0 cycle; returns in the next phase-0 cycle.
  task automatic run_slot(input vec_t v, input int idx, input bit skip_clkref0);
    logic [2:0] acks;
    logic [2:0] exp_acks;
    logic       is_rd;
    dio_req  = v.dio;  vid_req  = v.vid;  cpu_req = v.cpu; cpu_we = v.cwe;
    cpu_addr = v.caddr; cpu_din = v.cdin; dio_din = v.ddin;
    dio_addr = DIO_A;  vid_addr = VID_A;
    exp_acks = (v.g == 2'd1) ? 3'b100 : (v.g == 2'd2) ? 3'b010 :
               (v.g == 2'd3) ? 3'b001 : 3'b000;
    is_rd = (v.g == 2'd2) || ((v.g == 2'd3) && !v.we);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!(skip_clkref0 && c == 0))
        chk($sformatf("clkref s%0d p%0d", idx, c), 64'(sd_clkref), 64'(c < 4));
      if (c >= 1)
        chk($sformatf("drive s%0d p%0d", idx, c),
            64'({grant, sd_we, sd_oe, sd_addr, sd_din}),
            64'({v.g, v.we, v.oe, v.a, v.din}));
      acks = {dio_ack, vid_ack, cpu_ack};
      chk($sformatf("ack s%0d p%0d", idx, c), 64'(acks), 64'((c == 6) ? exp_acks : 3'b000));
      if (c == 6 && is_rd)
        chk($sformatf("rdata s%0d", idx), 64'((v.g == 2'd2) ? vid_dout : cpu_dout), 64'(v.rd));
      step();
      if (c == 2) begin
        // Perturb request payloads mid-slot; the latched values must be unaffected.
        cpu_addr = ~v.caddr; cpu_din = ~v.cdin; cpu_we = ~v.cwe;
        dio_din = ~v.ddin; dio_addr = ~DIO_A; vid_addr = ~VID_A;
      end
      if (c == 6) begin
        if (acks[2]) dio_req = 1'b0;
        if (acks[1]) vid_req = 1'b0;
        if (acks[0]) cpu_req = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    int ack_seen;

    tbl[0]  = mk(0,0,1,1, 23'h1F800, 8'h41, 8'h00, 2'd3, 1,0, 23'h1F800, 8'h41, 8'h00);
    tbl[1]  = mk(0,0,1,0, 23'h1F800, 8'h41, 8'h00, 2'd3, 0,1, 23'h1F800, 8'h41, 8'h41);
    tbl[2]  = mk(1,1,1,0, 23'h00300, 8'h00, 8'h99, 2'd1, 1,0, DIO_A,     8'h99, 8'h00);
    tbl[3]  = mk(0,1,1,0, 23'h00300, 8'h00, 8'h99, 2'd2, 0,1, VID_A,     8'h99, 8'h1A);
    tbl[4]  = mk(0,0,1,0, 23'h00300, 8'h00, 8'h99, 2'd3, 0,1, 23'h00300, 8'h00, 8'h5A);
    tbl[5]  = mk(0,1,1,0, 23'h1F800, 8'h00, 8'h00, 2'd2, 0,1, VID_A,     8'h00, 8'h1A);
    tbl[6]  = mk(0,1,1,0, 23'h1F800, 8'h00, 8'h00, 2'd2, 0,1, VID_A,     8'h00, 8'h1A);
    tbl[7]  = mk(0,1,1,0, 23'h1F800, 8'h00, 8'h00, 2'd3, 0,1, 23'h1F800, 8'h00, 8'h41);
    tbl[8]  = mk(0,1,0,0, 23'h1F800, 8'h00, 8'h00, 2'd2, 0,1, VID_A,     8'h00, 8'h1A);
    for (int i = 9; i < 13; i++)
      tbl[i] = mk(0,0,0,0, 23'h1F800, 8'h00, 8'h00, 2'd0, 0,0, VID_A, 8'h00, 8'h00);

    reset = 1'b1; mem_init = 1'b1;
    dio_req = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
    dio_addr = DIO_A; vid_addr = VID_A; cpu_addr = '0; cpu_din = '0; dio_din = '0;
    repeat (3) step();
    mem_init = 1'b0;
    @(negedge clk);
    chk("reset state",
        64'({sd_clkref, sd_we, sd_oe, sd_addr, sd_din, dio_ack, vid_ack, cpu_ack, grant}), 64'd0);
    chk("reset rdata", 64'({vid_dout, cpu_dout}), 64'd0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_slot(tbl[i], i, i == 0);

    // Late cpu request (phase 1) waits for the next slot; ack 13 clks later.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h1F800; cpu_din = 8'h00;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n <= 6) chk($sformatf("late idle n%0d", n), 64'(grant), 64'd0);
      if (cpu_ack) begin
        lat = n;
        break;
      end
      step();
    end
    chk("late cpu latency", 64'(lat), 64'd13);
    chk("late cpu rdata", 64'(cpu_dout), 64'h41);
    step();
    cpu_req = 1'b0;
    step();
    chk("late realign", 64'(ph), 64'd0);

    // Reset in phase 3 of a download write aborts the slot without an ack.
    dio_req = 1'b1; dio_addr = DIO_A; dio_din = 8'h77;
    repeat (3) step();
    reset = 1'b1;
    ack_seen = 0;
    step();
    @(negedge clk);
    chk("midreset drive", 64'({grant, sd_we, sd_oe, sd_addr, sd_din}), 64'd0);
    if (dio_ack) ack_seen++;
    step();
    @(negedge clk);
    if (dio_ack) ack_seen++;
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1)
        chk("post-reset dio grant", 64'({grant, sd_we, sd_oe, sd_addr, sd_din}),
            64'({2'd1, 1'b1, 1'b0, DIO_A, 8'h77}));
      if (c < 6 && dio_ack) ack_seen++;
      if (c == 6) chk("post-reset dio ack", 64'(dio_ack), 64'd1);
      step();
      if (c == 6) dio_req = 1'b0;
    end
    chk("no ack across reset", 64'(ack_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
